// File: rtl/alu.sv
// Two-stage signed arithmetic unit for the FIR datapath: add, multiply, subtract
// and multiply-accumulate on DATA_W-bit operands with an RES_W-bit result.
module alu #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [1:0]        op_sel,
  output logic signed [RES_W-1:0]  result
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  function automatic logic signed [RES_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return signed'({{(RES_W-DATA_W){x[DATA_W-1]}}, x});
  endfunction

  // RES_W = 2*DATA_W, so the widened product is exact, including -2^15 * -2^15.
  function automatic logic signed [RES_W-1:0] mul_full(input logic signed [DATA_W-1:0] x,
                                                       input logic signed [DATA_W-1:0] y);
    return sext(x) * sext(y);
  endfunction

  // Accumulation deliberately wraps modulo 2^RES_W; no saturation.
  function automatic logic signed [RES_W-1:0] wrap_add(input logic signed [RES_W-1:0] x,
                                                       input logic signed [RES_W-1:0] y);
    return x + y;
  endfunction

  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;
  op_e                      op_p1;
  logic signed [RES_W-1:0]  acc_p2;
  logic signed [RES_W-1:0]  prod_p1;
  logic signed [RES_W-1:0]  acc_nxt_p1;
  logic signed [RES_W-1:0]  res_nxt_p1;

  // Stage 1: operand and opcode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1  <= '0;
      b_p1  <= '0;
      op_p1 <= OP_ADD;
    end else begin
      a_p1  <= a;
      b_p1  <= b;
      op_p1 <= op_e'(op_sel);
    end
  end

  // Stage 2: combinational arithmetic on the captured operands.
  always_comb begin
    prod_p1    = mul_full(a_p1, b_p1);
    acc_nxt_p1 = wrap_add(acc_p2, prod_p1);
    res_nxt_p1 = '0;
    unique case (op_p1)
      OP_ADD:  res_nxt_p1 = wrap_add(sext(a_p1), sext(b_p1));
      OP_MUL:  res_nxt_p1 = prod_p1;
      OP_SUB:  res_nxt_p1 = sext(a_p1) - sext(b_p1);
      OP_MAC:  res_nxt_p1 = acc_nxt_p1;
      default: res_nxt_p1 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
      result <= '0;
    end else begin
      result <= res_nxt_p1;
      if (op_p1 == OP_MAC) acc_p2 <= acc_nxt_p1;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and randomized bench for alu; a transaction-level model predicts each result.
module tb_alu;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic        [1:0]  op_sel = '0;
  logic signed [31:0] result;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_acc  = '0;
  logic [31:0] m_next = '0;

  alu #(.DATA_W(16), .RES_W(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op_sel(op_sel), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (result === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)",
             tag, $signed(result), result, $signed(exp), exp);
    end
  endtask

  // One clock: present operands, take the edge, check the slot that completes there.
  task automatic cycle(input logic signed [15:0] ta, input logic signed [15:0] tb_,
                       input logic [1:0] top, input logic trst, input string tag);
    longint la, lb, v;
    a = ta; b = tb_; op_sel = top; rst = trst;
    @(posedge clk);
    #1;
    if (trst) begin
      check({tag, "_rst"}, 32'h0);
      m_acc  = '0;
      m_next = '0;   // stage 1 cleared: next slot is 0+0
    end else begin
      check(tag, m_next);
      la = ta; lb = tb_;
      case (top)
        2'b00: v = la + lb;
        2'b01: v = la * lb;
        2'b10: v = la - lb;
        default: begin
          m_acc = m_acc + 32'(la * lb);
          v = longint'($signed(m_acc));
        end
      endcase
      m_next = 32'(v);
    end
  endtask

  initial begin
    logic signed [15:0] ra, rb;
    logic [1:0]         rop;
    logic               rr;

    // Reset held two edges with a full-scale multiply pending
    cycle(16'sh7FFF, 16'sh7FFF, 2'b01, 1'b1, "reset0");
    cycle(16'sh7FFF, 16'sh7FFF, 2'b01, 1'b1, "reset1");
    cycle(16'sh7FFF, 16'sh7FFF, 2'b01, 1'b0, "post_reset");
    check("post_reset_zero", 32'h0);

    // Add
    cycle(16'sd100, -16'sd3, 2'b00, 1'b0, "mul_max");
    check("mul_max_lit", 32'd1073676289);
    cycle(16'sd100, -16'sd3, 2'b00, 1'b0, "add_a");
    cycle(16'sd100, -16'sd3, 2'b00, 1'b0, "add_b");
    check("add_97", 32'h00000061);
    cycle(-16'sd32768, -16'sd32768, 2'b00, 1'b0, "add_c");
    cycle(-16'sd32768, -16'sd32768, 2'b00, 1'b0, "add_min");
    check("add_min_lit", 32'hFFFF0000);

    // Multiply
    cycle(-16'sd2, 16'sd3, 2'b01, 1'b0, "mul_a");
    cycle(16'sd32767, 16'sd32767, 2'b01, 1'b0, "mul_neg");
    check("mul_neg6", 32'hFFFFFFFA);
    cycle(-16'sd32768, -16'sd32768, 2'b01, 1'b0, "mul_pos");
    check("mul_32767sq", 32'd1073676289);
    cycle(16'sd0, 16'sd0, 2'b00, 1'b0, "mul_min");
    check("mul_min_lit", 32'h40000000);

    // Back-to-back: add, mul, sub on consecutive slots
    cycle(16'sd1, 16'sd1, 2'b00, 1'b0, "b2b_0");
    cycle(16'sd4, 16'sd5, 2'b01, 1'b0, "b2b_1");
    check("b2b_add", 32'd2);
    cycle(16'sd10, 16'sd20, 2'b10, 1'b0, "b2b_2");
    check("b2b_mul", 32'd20);
    cycle(16'sd0, 16'sd0, 2'b00, 1'b0, "b2b_3");
    check("b2b_sub", 32'hFFFFFFF6);

    // MAC from reset, interrupted by an add, then resumed
    cycle(16'sd0, 16'sd0, 2'b00, 1'b1, "mac_rst");
    cycle(16'sd3, 16'sd4, 2'b11, 1'b0, "mac_0");
    cycle(-16'sd2, 16'sd5, 2'b11, 1'b0, "mac_1");
    check("mac_12", 32'd12);
    cycle(16'sd100, 16'sd100, 2'b11, 1'b0, "mac_2");
    check("mac_2", 32'd2);
    cycle(16'sd1, 16'sd1, 2'b00, 1'b0, "mac_3");
    check("mac_10002", 32'd10002);
    cycle(16'sd1, 16'sd1, 2'b11, 1'b0, "mac_4");
    check("mac_add2", 32'd2);
    cycle(16'sd0, 16'sd0, 2'b00, 1'b0, "mac_5");
    check("mac_held_10003", 32'd10003);

    // Reset mid-MAC discards the accumulator and the in-flight slot
    cycle(16'sd0, 16'sd0, 2'b00, 1'b1, "mid_rst0");
    cycle(16'sd3, 16'sd4, 2'b11, 1'b0, "mid_0");
    cycle(-16'sd2, 16'sd5, 2'b11, 1'b0, "mid_1");
    cycle(16'sd100, 16'sd100, 2'b11, 1'b0, "mid_2");
    cycle(16'sd50, 16'sd50, 2'b11, 1'b0, "mid_3");
    check("mid_10002", 32'd10002);
    cycle(16'sd0, 16'sd0, 2'b00, 1'b1, "mid_rst1");
    cycle(16'sd2, 16'sd2, 2'b11, 1'b0, "mid_4");
    check("mid_after_rst_zero", 32'h0);
    cycle(16'sd0, 16'sd0, 2'b00, 1'b0, "mid_5");
    check("mid_mac4", 32'd4);

    // Randomized mix with occasional resets and full-scale operands
    for (int i = 0; i < 400; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
      rop = 2'($urandom_range(0, 3));
      rr  = ($urandom_range(0, 39) == 0);
      cycle(ra, rb, rop, rr, "rand");
    end
    cycle(16'sd0, 16'sd0, 2'b00, 1'b0, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Pipelined signed 16-bit arithmetic unit for the FIR core datapath.
- Performs add, multiply, subtract or multiply-accumulate on two 16-bit operands, selected per cycle.
- Typical operands: one input sample and one filter coefficient.
- Produces a 32-bit two's-complement result two clock edges after the operands are presented; accepts one new operation every cycle.

Parameters:
- DATA_W, 16, operand width (two's complement).
- RES_W, 32, result/accumulator width; must be 2*DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  16  signed operand A (sample).
- b  input  16  signed operand B (coefficient).
- op_sel  input  2  operation select: 00 add, 01 multiply, 10 subtract, 11 multiply-accumulate.
- result  output  32  signed registered result.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: when rst=1 at a rising edge, clear all registers to 0 (operand regs, op register, accumulator, result). rst has priority over any operation. result reads 0 from the edge after rst is sampled until the first post-reset result emerges.
- Stage 1, edge N: register a, b, op_sel into a_q, b_q, op_q.
- Stage 2, edge N+1: compute from a_q, b_q, op_q and register into result.
- Latency: an operand set stable before edge N is visible on result after edge N+1 and holds through edge N+2 if inputs are unchanged.
- Throughput: one operation per cycle, no stalls, no handshake.
- Operations (all signed, computed modulo 2^32, no saturation, no flags):
  - 00 add: result = sext32(a_q) + sext32(b_q). Range -65536..65534; never wraps.
  - 01 multiply: result = full signed 16x16 product. -32768*-32768 = 0x40000000 must be exact.
  - 10 subtract: result = sext32(a_q) - sext32(b_q).
  - 11 multiply-accumulate: acc <= acc + a_q*b_q and result <= the new acc value. Wraps modulo 2^32 on overflow.
- Accumulator:
  - Modified only by op 11 and by reset.
  - Ops 00/01/10 leave acc unchanged, so a later op 11 continues from the held value.
- op_sel changes between cycles take effect per operation; no cross-contamination between consecutive pipeline slots.
- Reset mid-operation: in-flight stage-1 data is discarded; no result from pre-reset operands appears after reset.
- Implementation: purely synchronous, no latches. Multiplier may be behavioural or structural but must be signed and complete within stage 2.

Test Plan:
- Reset: hold rst=1 for 2 edges with a=0x7FFF, b=0x7FFF, op_sel=01 -> result=0 throughout reset and on the edge after rst deasserts.
- Add: a=100, b=-3, op 00 held 3 edges -> result=97 (0x00000061); then a=-32768, b=-32768 -> result=-65536 (0xFFFF0000).
- Multiply: a=-2, b=3, op 01 -> 0xFFFFFFFA (-6). a=32767, b=32767 -> 1073676289. a=-32768, b=-32768 -> 0x40000000.
- Back-to-back latency: one new op per cycle (add 1+1, mul 4*5, sub 10-20) -> result sequence 2, 20, -10, each appearing exactly 2 edges after its operands.
- MAC: after reset, three consecutive op 11 cycles with (3,4), (-2,5), (100,100) -> result 12, 2, 10002. Then one op 00 (1+1) -> 2. Then op 11 (1,1) -> 10003, showing acc was held.
- Reset mid-MAC: accumulate to 10002, assert rst for 1 edge, then op 11 (2,2) -> result 4.
